// File: rtl/switch_pkg.sv
// Shared switch types: port addresses, packet layout at the default payload width, counter width.
package switch_pkg;
  typedef logic [1:0] port_id_t;

  localparam int NUM_PORTS  = 4;
  localparam int CNT_W      = 8;
  localparam int PKT_DATA_W = 8;

  typedef struct packed {
    port_id_t                source;
    port_id_t                target;
    logic [PKT_DATA_W-1:0]   data;
  } pkt_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is accepted
// when a pop happens in the same cycle. The head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/switch_port_host.sv
// Host endpoint of one switch port: buffered TX into the switch, buffered RX out of it.
// Statistics counters are built only when SWITCH_PORT_HOST_STATS_EN is defined.
module switch_port_host
  import switch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        tx_target,
  input  logic [DATA_W-1:0] tx_data,
  output logic              sw_valid_in,
  output logic [1:0]        sw_source_in,
  output logic [1:0]        sw_target_in,
  output logic [DATA_W-1:0] sw_data_in,
  input  logic              sw_ready_out,
  input  logic              sw_valid_out,
  input  logic [1:0]        sw_source_out,
  input  logic [1:0]        sw_target_out,
  input  logic [DATA_W-1:0] sw_data_out,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [1:0]        rx_source,
  output logic [DATA_W-1:0] rx_data,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  misroute_cnt,
  output logic [CNT_W-1:0]  self_cnt
);
  localparam port_id_t MY_ID = port_id_t'(PORT_ID);
  localparam int       PW    = 2 + DATA_W;

  typedef enum logic {IDLE, SEND} tx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [PW-1:0] tx_head;
  logic          rx_full, rx_empty;
  logic [PW-1:0] rx_head;
  logic          tx_self, rx_drop, rx_misroute;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready && (tx_target != MY_ID);
  assign tx_self  = tx_valid && tx_ready && (tx_target == MY_ID);

  sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .wr_en(tx_push), .wr_data({tx_target, tx_data}),
    .rd_en(tx_pop), .rd_data(tx_head),
    .full(tx_full), .empty(tx_empty)
  );

  // p1: output register toward the switch, held while the switch stalls
  tx_state_e         state_p1;
  logic              vld_p1;
  port_id_t          target_p1;
  logic [DATA_W-1:0] data_p1;

  assign tx_pop = !tx_empty && ((state_p1 == IDLE) || sw_ready_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1  <= IDLE;
      vld_p1    <= 1'b0;
      target_p1 <= '0;
      data_p1   <= '0;
    end else begin
      case (state_p1)
        IDLE: begin
          if (!tx_empty) begin
            {target_p1, data_p1} <= tx_head;
            vld_p1               <= 1'b1;
            state_p1             <= SEND;
          end
        end
        SEND: begin
          if (sw_ready_out) begin
            if (!tx_empty) begin
              {target_p1, data_p1} <= tx_head;
            end else begin
              vld_p1   <= 1'b0;
              state_p1 <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign sw_valid_in  = vld_p1;
  assign sw_source_in = MY_ID;
  assign sw_target_in = target_p1;
  assign sw_data_in   = data_p1;

  sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .wr_en(sw_valid_out), .wr_data({sw_source_out, sw_data_out}),
    .rd_en(rx_ready), .rd_data(rx_head),
    .full(rx_full), .empty(rx_empty)
  );

  assign rx_valid               = !rx_empty;
  assign {rx_source, rx_data}   = rx_head;
  // A full FIFO still accepts the packet when the client pops in the same cycle
  assign rx_drop     = sw_valid_out && rx_full && !rx_ready;
  assign rx_misroute = sw_valid_out && (sw_target_out != MY_ID);

`ifdef SWITCH_PORT_HOST_STATS_EN
  logic [CNT_W-1:0] drop_q, misroute_q, self_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q     <= '0;
      misroute_q <= '0;
      self_q     <= '0;
    end else begin
      if (rx_drop)     drop_q     <= sat_inc(drop_q);
      if (rx_misroute) misroute_q <= sat_inc(misroute_q);
      if (tx_self)     self_q     <= sat_inc(self_q);
    end
  end

  assign drop_cnt     = drop_q;
  assign misroute_cnt = misroute_q;
  assign self_cnt     = self_q;
`else
  logic unused_stats;
  assign unused_stats = ^{rx_drop, rx_misroute, tx_self, sat_inc('0)};
  assign drop_cnt     = '0;
  assign misroute_cnt = '0;
  assign self_cnt     = '0;
`endif
endmodule

// File: tb/tb_switch_port_host.sv
// Self-checking bench for switch_port_host with PORT_ID=0: directed scenarios plus a
// randomized run checked against a queue-level model of the TX and RX paths.
module tb_switch_port_host;
  import switch_pkg::*;

  localparam int DW    = 8;
  localparam int ID    = 0;
  localparam int DEPTH = 4;
`ifdef SWITCH_PORT_HOST_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          tx_valid, tx_ready;
  logic [1:0]    tx_target;
  logic [DW-1:0] tx_data;
  logic          sw_valid_in;
  logic [1:0]    sw_source_in, sw_target_in;
  logic [DW-1:0] sw_data_in;
  logic          sw_ready_out, sw_valid_out;
  logic [1:0]    sw_source_out, sw_target_out;
  logic [DW-1:0] sw_data_out;
  logic          rx_valid, rx_ready;
  logic [1:0]    rx_source;
  logic [DW-1:0] rx_data;
  logic [7:0]    drop_cnt, misroute_cnt, self_cnt;

  int errors = 0;
  int checks = 0;

  switch_port_host #(.DATA_W(DW), .PORT_ID(ID), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_target(tx_target), .tx_data(tx_data),
    .sw_valid_in(sw_valid_in), .sw_source_in(sw_source_in), .sw_target_in(sw_target_in),
    .sw_data_in(sw_data_in), .sw_ready_out(sw_ready_out),
    .sw_valid_out(sw_valid_out), .sw_source_out(sw_source_out), .sw_target_out(sw_target_out),
    .sw_data_out(sw_data_out),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_source(rx_source), .rx_data(rx_data),
    .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt), .self_cnt(self_cnt)
  );

  function automatic logic [7:0] exp_cnt(input int n);
    if (!STATS_ON) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_valid = 0; tx_target = 0; tx_data = 0;
    sw_ready_out = 0; sw_valid_out = 0; sw_source_out = 0; sw_target_out = 0; sw_data_out = 0;
    rx_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    checks++;
    if (sw_valid_in !== 1'b0 || sw_source_in !== 2'(ID) || sw_target_in !== 2'd0 || sw_data_in !== 8'd0) begin
      errors++;
      $display("FAIL reset_sw got v=%b s=%0d t=%0d d=%h exp v=0 s=%0d t=0 d=00", sw_valid_in, sw_source_in, sw_target_in, sw_data_in, ID);
    end
    checks++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_source !== 2'd0 || rx_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_client got txr=%b rxv=%b rxs=%0d rxd=%h exp 1 0 0 00", tx_ready, rx_valid, rx_source, rx_data);
    end
    checks++;
    if (drop_cnt !== 8'd0 || misroute_cnt !== 8'd0 || self_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d %0d %0d exp 0 0 0", drop_cnt, misroute_cnt, self_cnt);
    end
    step();
    rst = 0;
  endtask

  task automatic test_single_push();
    do_reset();
    tx_valid = 1; tx_target = 2; tx_data = 8'hA5;
    step();
    tx_valid = 0;
    checks++;
    if (sw_valid_in !== 1'b0) begin
      errors++; $display("FAIL single_early got v=%b exp 0", sw_valid_in);
    end
    step();
    checks++;
    if (sw_valid_in !== 1'b1 || sw_source_in !== 2'd0 || sw_target_in !== 2'd2 || sw_data_in !== 8'hA5) begin
      errors++;
      $display("FAIL single_out got v=%b s=%0d t=%0d d=%h exp v=1 s=0 t=2 d=a5", sw_valid_in, sw_source_in, sw_target_in, sw_data_in);
    end
    step();
    step();
    checks++;
    if (sw_valid_in !== 1'b1 || sw_data_in !== 8'hA5) begin
      errors++; $display("FAIL single_hold got v=%b d=%h exp v=1 d=a5", sw_valid_in, sw_data_in);
    end
    sw_ready_out = 1;
    step();
    sw_ready_out = 0;
    checks++;
    if (sw_valid_in !== 1'b0) begin
      errors++; $display("FAIL single_drop got v=%b exp 0", sw_valid_in);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]    tg [5];
    logic [DW-1:0] dt [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tg[i] = 2'(1 + (i % 3));
      dt[i] = 8'(8'h10 + i);
      tx_valid = 1; tx_target = tg[i]; tx_data = dt[i];
      checks++;
      if (tx_ready !== 1'b1) begin
        errors++; $display("FAIL bp_ready_push%0d got %b exp 1", i, tx_ready);
      end
      step();
    end
    tx_valid = 1; tx_target = 2; tx_data = 8'hEE;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full got tx_ready=%b exp 0", tx_ready);
    end
    step();
    tx_valid = 0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (sw_valid_in !== 1'b1 || sw_target_in !== tg[0] || sw_data_in !== dt[0]) begin
        errors++;
        $display("FAIL bp_stable%0d got v=%b t=%0d d=%h exp v=1 t=%0d d=%h", c, sw_valid_in, sw_target_in, sw_data_in, tg[0], dt[0]);
      end
      step();
    end
    sw_ready_out = 1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sw_valid_in !== 1'b1 || sw_target_in !== tg[k] || sw_data_in !== dt[k]) begin
        errors++;
        $display("FAIL bp_burst%0d got v=%b t=%0d d=%h exp v=1 t=%0d d=%h", k, sw_valid_in, sw_target_in, sw_data_in, tg[k], dt[k]);
      end
      step();
    end
    checks++;
    if (sw_valid_in !== 1'b0) begin
      errors++; $display("FAIL bp_after got v=%b d=%h exp v=0", sw_valid_in, sw_data_in);
    end
    sw_ready_out = 0;
  endtask

  task automatic test_self_push();
    do_reset();
    sw_ready_out = 1;
    tx_valid = 1; tx_target = 2'(ID); tx_data = 8'h5A;
    step();
    tx_valid = 0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (sw_valid_in !== 1'b0) begin
        errors++; $display("FAIL self_nosend%0d got v=%b exp 0", c, sw_valid_in);
      end
      step();
    end
    checks++;
    if (self_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL self_cnt got %0d exp %0d", self_cnt, exp_cnt(1));
    end
    sw_ready_out = 0;
  endtask

  task automatic test_rx_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      sw_valid_out = 1; sw_source_out = 2'd1; sw_target_out = 2'(ID); sw_data_out = 8'(i);
      step();
      if (i == 1) begin
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'd1 || rx_source !== 2'd1) begin
          errors++; $display("FAIL rx_latency got v=%b d=%h s=%0d exp v=1 d=01 s=1", rx_valid, rx_data, rx_source);
        end
      end
    end
    sw_valid_out = 0;
    step();
    checks++;
    if (rx_valid !== 1'b1 || drop_cnt !== exp_cnt(2)) begin
      errors++; $display("FAIL rx_ovf got v=%b drop=%0d exp v=1 drop=%0d", rx_valid, drop_cnt, exp_cnt(2));
    end
    rx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
        errors++; $display("FAIL rx_pop%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, 8'(i));
      end
      step();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL rx_empty got v=%b d=%h exp v=0", rx_valid, rx_data);
    end
    rx_ready = 0;
  endtask

  task automatic test_misroute();
    do_reset();
    rx_ready = 1;
    sw_valid_out = 1; sw_source_out = 2'd1; sw_target_out = 2'd3; sw_data_out = 8'h3C;
    step();
    sw_valid_out = 0;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_source !== 2'd1) begin
      errors++; $display("FAIL mis_deliver got v=%b d=%h s=%0d exp v=1 d=3c s=1", rx_valid, rx_data, rx_source);
    end
    step();
    checks++;
    if (misroute_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL mis_cnt1 got %0d exp %0d", misroute_cnt, exp_cnt(1));
    end
    for (int i = 0; i < 300; i++) begin
      sw_valid_out = 1; sw_target_out = 2'd3; sw_data_out = 8'(i);
      step();
    end
    sw_valid_out = 0;
    step();
    checks++;
    if (misroute_cnt !== exp_cnt(301) || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL mis_sat got mis=%0d drop=%0d exp mis=%0d drop=0", misroute_cnt, drop_cnt, exp_cnt(301));
    end
    rx_ready = 0;
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1; tx_target = 2'd1; tx_data = 8'(8'h40 + i);
      step();
    end
    tx_valid = 0;
    step();
    checks++;
    if (sw_valid_in !== 1'b1 || sw_data_in !== 8'h40) begin
      errors++; $display("FAIL rst_pre got v=%b d=%h exp v=1 d=40", sw_valid_in, sw_data_in);
    end
    #3;
    rst = 1;
    #1;
    checks++;
    if (sw_valid_in !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async got v=%b txr=%b exp v=0 txr=1", sw_valid_in, tx_ready);
    end
    step();
    rst = 0;
    sw_ready_out = 1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (sw_valid_in !== 1'b0) begin
        errors++; $display("FAIL rst_quiet%0d got v=%b d=%h exp v=0", c, sw_valid_in, sw_data_in);
      end
      step();
    end
    tx_valid = 1; tx_target = 2'd3; tx_data = 8'h77;
    step();
    tx_valid = 0;
    step();
    checks++;
    if (sw_valid_in !== 1'b1 || sw_target_in !== 2'd3 || sw_data_in !== 8'h77) begin
      errors++; $display("FAIL rst_newpush got v=%b t=%0d d=%h exp v=1 t=3 d=77", sw_valid_in, sw_target_in, sw_data_in);
    end
    step();
    checks++;
    if (sw_valid_in !== 1'b0) begin
      errors++; $display("FAIL rst_newdone got v=%b exp 0", sw_valid_in);
    end
    sw_ready_out = 0;
  endtask

  task automatic test_random();
    pkt_t txq[$];
    pkt_t rxq[$];
    pkt_t p;
    int   n_self = 0, n_drop = 0, n_mis = 0;
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc < 600) begin
        tx_valid      = ($urandom_range(0, 2) != 0);
        tx_target     = 2'($urandom_range(0, 3));
        tx_data       = 8'($urandom);
        sw_ready_out  = ($urandom_range(0, 3) != 0);
        sw_valid_out  = ($urandom_range(0, 1) != 0);
        sw_source_out = 2'($urandom_range(0, 3));
        sw_target_out = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'(ID);
        sw_data_out   = 8'($urandom);
        rx_ready      = ($urandom_range(0, 2) == 0);
      end else begin
        tx_valid = 0; sw_valid_out = 0; sw_ready_out = 1; rx_ready = 1;
      end
      if (sw_valid_in && sw_ready_out) begin
        checks++;
        if (txq.size() == 0) begin
          errors++; $display("FAIL rnd_tx_spurious cyc=%0d got d=%h exp no packet", cyc, sw_data_in);
        end else begin
          p = txq.pop_front();
          if (sw_source_in !== 2'(ID) || sw_target_in !== p.target || sw_data_in !== p.data) begin
            errors++;
            $display("FAIL rnd_tx cyc=%0d got s=%0d t=%0d d=%h exp s=%0d t=%0d d=%h", cyc, sw_source_in, sw_target_in, sw_data_in, ID, p.target, p.data);
          end
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_target == 2'(ID)) n_self++;
        else begin
          p.source = 2'(ID); p.target = tx_target; p.data = tx_data;
          txq.push_back(p);
        end
      end
      checks++;
      if (rx_valid !== (rxq.size() > 0)) begin
        errors++; $display("FAIL rnd_rx_valid cyc=%0d got %b exp %b", cyc, rx_valid, rxq.size() > 0);
      end else if (rxq.size() > 0 && (rx_source !== rxq[0].source || rx_data !== rxq[0].data)) begin
        errors++;
        $display("FAIL rnd_rx_head cyc=%0d got s=%0d d=%h exp s=%0d d=%h", cyc, rx_source, rx_data, rxq[0].source, rxq[0].data);
      end
      if (rx_ready && rxq.size() > 0) void'(rxq.pop_front());
      if (sw_valid_out) begin
        if (sw_target_out != 2'(ID)) n_mis++;
        if (rxq.size() < DEPTH) begin
          p.source = sw_source_out; p.target = sw_target_out; p.data = sw_data_out;
          rxq.push_back(p);
        end else n_drop++;
      end
      step();
    end
    checks++;
    if (txq.size() != 0 || sw_valid_in !== 1'b0) begin
      errors++; $display("FAIL rnd_tx_drain got pending=%0d v=%b exp 0 0", txq.size(), sw_valid_in);
    end
    checks++;
    if (self_cnt !== exp_cnt(n_self) || drop_cnt !== exp_cnt(n_drop) || misroute_cnt !== exp_cnt(n_mis)) begin
      errors++;
      $display("FAIL rnd_cnt got self=%0d drop=%0d mis=%0d exp %0d %0d %0d", self_cnt, drop_cnt, misroute_cnt, exp_cnt(n_self), exp_cnt(n_drop), exp_cnt(n_mis));
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_backpressure();
    test_self_push();
    test_rx_overflow();
    test_misroute();
    test_reset_mid_send();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
